// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multicycle controller: FSM state encodings,
// opcode constants, instruction classes, ALU control codes and mux selects.
package rv32i_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALRA    = 4'd11,
        S_JALRB    = 4'd12,
        S_LUI      = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_LOAD, CLS_STORE, CLS_OP, CLS_OP_IMM, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_OTHER
    } op_class_t;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SLTU = 5'b11000;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    // Collapse the 7-bit opcode into the handful of classes the FSM cares about
    function automatic op_class_t classify(input logic [6:0] opc);
        case (opc)
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_OP:     return CLS_OP;
            OPC_OP_IMM: return CLS_OP_IMM;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_JAL:    return CLS_JAL;
            OPC_JALR:   return CLS_JALR;
            OPC_LUI:    return CLS_LUI;
            OPC_AUIPC:  return CLS_AUIPC;
            default:    return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU control decoder: picks the ALU operation for the current state and flags
// instruction encodings this core does not implement.
module alu_dec
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  op_class_t  op_class,
    input  state_t     state,
    output logic [4:0] alucont,
    output logic       unsupported
);

    logic [4:0] arith_code;
    logic       arith_ok;
    logic       is_r;

    // Decode the arithmetic function; funct7b5 only selects SUB on R-type ADD
    always_comb begin
        is_r       = (op_class == CLS_OP);
        arith_code = ALU_ADD;
        arith_ok   = 1'b1;
        case (funct3)
            3'b000: arith_code = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111: arith_code = ALU_AND;
            3'b110: arith_code = ALU_OR;
            3'b100: arith_code = ALU_XOR;
            3'b011: arith_code = ALU_SLTU;
            default: arith_ok  = 1'b0;
        endcase
        // funct7b5 on anything but ADD/SUB is SRA-style territory: not supported
        if (is_r && funct7b5 && (funct3 != 3'b000)) begin
            arith_ok = 1'b0;
        end
    end

    // Per-state ALU operation and the unsupported-encoding flag used in DECODE
    always_comb begin
        unsupported = 1'b0;
        if ((op_class == CLS_OP || op_class == CLS_OP_IMM) && !arith_ok) begin
            unsupported = 1'b1;
        end
        if (op_class == CLS_BRANCH && funct3[2:1] == 2'b01) begin
            unsupported = 1'b1;
        end
        case (state)
            S_EXECR, S_EXECI: alucont = arith_ok ? arith_code : ALU_ADD;
            S_BRANCH:         alucont = ALU_SUB;
            default:          alucont = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute, owns the memory
// request handshake and drives every datapath enable and mux select.
module rv32i_mc_ctrl
    import rv32i_pkg::*;
#(
    parameter int STATE_W = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               N,
    input  logic               Z,
    input  logic               C,
    input  logic               V,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               adrsrc,
    output logic               ir_we,
    output logic               pc_we,
    output logic               rf_we,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         resultsrc,
    output logic [4:0]         alucont,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_t     state_reg, state_next;
    op_class_t  op_class;
    logic [4:0] dec_alucont;
    logic       dec_unsupported;
    logic       branch_taken;

    assign op_class = classify(opcode);

    alu_dec u_alu_dec (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op_class    (op_class),
        .state       (state_reg),
        .alucont     (dec_alucont),
        .unsupported (dec_unsupported)
    );

    // Branch condition from the flags of the same-cycle A - B comparison
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = Z;
            3'b001:  branch_taken = !Z;
            3'b100:  branch_taken = N ^ V;
            3'b101:  branch_taken = !(N ^ V);
            3'b110:  branch_taken = !C;
            3'b111:  branch_taken = C;
            default: branch_taken = 1'b0;
        endcase
    end

    // State register; reset can arrive at any point, including mid-handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and output decode; reset overrides every output so no
    // request or write pulse leaks while the core is held
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adrsrc     = ADR_PC;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_REGB;
        resultsrc  = RES_ALUOUT;
        alucont    = dec_alucont;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                adrsrc    = ADR_PC;
                alusrca   = SRCA_PC;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op_class)
                    CLS_LOAD, CLS_STORE: state_next = S_MEMADR;
                    CLS_OP:              state_next = S_EXECR;
                    CLS_OP_IMM:          state_next = S_EXECI;
                    CLS_BRANCH:          state_next = S_BRANCH;
                    CLS_JAL:             state_next = S_JAL;
                    CLS_JALR:            state_next = S_JALRA;
                    CLS_LUI:             state_next = S_LUI;
                    CLS_AUIPC:           state_next = S_ALUWB;
                    default:             state_next = S_ILLEGAL;
                endcase
                if (dec_unsupported) begin
                    state_next = S_ILLEGAL;
                end
            end
            S_MEMADR: begin
                alusrca    = SRCA_REGA;
                alusrcb    = SRCB_IMM;
                state_next = (op_class == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = ADR_ALUOUT;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultsrc  = RES_DATA;
                rf_we      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adrsrc  = ADR_ALUOUT;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                alusrca    = SRCA_REGA;
                alusrcb    = SRCB_REGB;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alusrca    = SRCA_REGA;
                alusrcb    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                resultsrc  = RES_ALUOUT;
                rf_we      = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = SRCA_REGA;
                alusrcb    = SRCB_REGB;
                resultsrc  = RES_ALUOUT;
                pc_we      = branch_taken;
                state_next = S_FETCH;
            end
            S_JAL: begin
                pc_we      = 1'b1;
                resultsrc  = RES_ALUOUT;
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                state_next = S_ALUWB;
            end
            S_JALRA: begin
                alusrca    = SRCA_REGA;
                alusrcb    = SRCB_IMM;
                state_next = S_JALRB;
            end
            S_JALRB: begin
                pc_we      = 1'b1;
                resultsrc  = RES_ALUOUT;
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                alusrca    = SRCA_ZERO;
                alusrcb    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                state_next = S_ILLEGAL;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            adrsrc    = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            rf_we     = 1'b0;
            alusrca   = 2'b00;
            alusrcb   = 2'b00;
            resultsrc = 2'b00;
            alucont   = 5'b00000;
            illegal   = 1'b0;
        end
    end

    assign state = STATE_W'(state_reg);

endmodule
